// File: rtl/accum_delta.sv
// Recovers per-step increments from a stream of running sums (first differences
// modulo 2^OUT_WIDTH), flagging differences that do not fit in IN_WIDTH bits.
module accum_delta #(
  parameter int IN_WIDTH        = 16,
  parameter int OUT_WIDTH       = 32,
  parameter int FIRST_FROM_ZERO = 1,
  parameter int DROP_ZERO       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [OUT_WIDTH-1:0] s_sum,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [IN_WIDTH-1:0]  m_delta,
  output logic                 m_ovf,
  output logic [7:0]           ovf_cnt
);

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam state_t RST_STATE = (FIRST_FROM_ZERO != 0) ? RUN : PRIME;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [OUT_WIDTH-1:0]  r_prev;
  logic                  r_valid;
  logic [IN_WIDTH-1:0]   r_delta;
  logic                  r_ovf;
  logic [7:0]            r_ovf_cnt;

  logic                  w_accept;
  logic                  w_emit;
  logic                  w_load;
  logic                  w_drop;
  logic                  w_ovf;
  logic [OUT_WIDTH-1:0]  w_diff;

  // Unsigned subtraction wraps naturally, so accumulator rollover is transparent.
  assign w_diff   = s_sum - r_prev;
  assign w_drop   = (DROP_ZERO != 0) && (w_diff == '0);

  generate
    if (OUT_WIDTH > IN_WIDTH) begin : g_ovf
      assign w_ovf = |w_diff[OUT_WIDTH-1:IN_WIDTH];
    end else begin : g_no_ovf
      assign w_ovf = 1'b0;
    end
  endgenerate

  assign s_ready  = (r_state == PRIME) || restart || !r_valid || m_ready;
  assign w_accept = s_valid && s_ready;
  assign w_emit   = r_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      PRIME: begin
        if (w_accept) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_accept && !restart && !w_drop) w_load = 1'b1;
      end
      default: w_state_nxt = RST_STATE;
    endcase
    // A restart re-primes; a sample taken alongside it becomes the new reference.
    if (restart) w_state_nxt = w_accept ? RUN : PRIME;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_valid   <= 1'b0;
      r_delta   <= '0;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_accept) r_prev <= s_sum;
      if (w_load) begin
        r_valid <= 1'b1;
        r_delta <= w_diff[IN_WIDTH-1:0];
        r_ovf   <= w_ovf;
      end else if (w_emit) begin
        r_valid <= 1'b0;
      end
      if (w_emit && r_ovf && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign m_valid = r_valid;
  assign m_delta = r_delta;
  assign m_ovf   = r_ovf;
  assign ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_accum_delta.sv
// Bench for accum_delta: three configurations driven by directed and random
// stimulus, checked every cycle against a transaction-level reference model.
module tb_accum_delta;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rs  = '0;
  logic [2:0]  sv  = '0;
  logic [2:0]  mr  = '0;
  logic [31:0] sum [3];

  logic [2:0]  srdy, mval, movf;
  logic [7:0]  ocnt [3];
  logic [15:0] d0, d1;
  logic [3:0]  d2;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  // Configuration of each instance, as seen by the model
  int FFZ [3] = '{1, 0, 1};
  int DZ  [3] = '{0, 0, 1};
  int IW  [3] = '{16, 16, 4};
  int OW  [3] = '{32, 32, 8};

  always #5 clk = ~clk;

  accum_delta #(.IN_WIDTH(16), .OUT_WIDTH(32), .FIRST_FROM_ZERO(1), .DROP_ZERO(0)) u0 (
    .clk(clk), .rst(rst), .restart(rs[0]), .s_valid(sv[0]), .s_ready(srdy[0]),
    .s_sum(sum[0]), .m_valid(mval[0]), .m_ready(mr[0]), .m_delta(d0),
    .m_ovf(movf[0]), .ovf_cnt(ocnt[0]));

  accum_delta #(.IN_WIDTH(16), .OUT_WIDTH(32), .FIRST_FROM_ZERO(0), .DROP_ZERO(0)) u1 (
    .clk(clk), .rst(rst), .restart(rs[1]), .s_valid(sv[1]), .s_ready(srdy[1]),
    .s_sum(sum[1]), .m_valid(mval[1]), .m_ready(mr[1]), .m_delta(d1),
    .m_ovf(movf[1]), .ovf_cnt(ocnt[1]));

  accum_delta #(.IN_WIDTH(4), .OUT_WIDTH(8), .FIRST_FROM_ZERO(1), .DROP_ZERO(1)) u2 (
    .clk(clk), .rst(rst), .restart(rs[2]), .s_valid(sv[2]), .s_ready(srdy[2]),
    .s_sum(sum[2][7:0]), .m_valid(mval[2]), .m_ready(mr[2]), .m_delta(d2),
    .m_ovf(movf[2]), .ovf_cnt(ocnt[2]));

  function automatic logic [15:0] get_delta(input int i);
    case (i)
      0:       return d0;
      1:       return d1;
      default: return {12'h000, d2};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: expected output register contents per instance
  logic [2:0]  e_valid, e_primed, e_ovf;
  logic [63:0] e_delta [3];
  logic [63:0] e_ref   [3];
  int          e_cnt   [3];

  always @(posedge clk) begin
    logic [63:0] om, d;
    logic rdy, acc, emit;
    for (int i = 0; i < 3; i++) begin
      om = (64'd1 << OW[i]) - 64'd1;
      if (rst) begin
        e_valid[i] = 1'b0; e_delta[i] = '0; e_ovf[i] = 1'b0; e_cnt[i] = 0;
        e_ref[i] = '0; e_primed[i] = (FFZ[i] != 0);
      end else begin
        rdy  = !e_primed[i] || rs[i] || !e_valid[i] || mr[i];
        acc  = sv[i] && rdy;
        emit = e_valid[i] && mr[i];
        if (emit && e_ovf[i] && e_cnt[i] < 255) e_cnt[i]++;
        if (emit) e_valid[i] = 1'b0;
        if (acc) begin
          if (e_primed[i] && !rs[i]) begin
            d = ({32'h0, sum[i]} - e_ref[i]) & om;
            if (!(DZ[i] != 0 && d == 0)) begin
              e_delta[i] = d & ((64'd1 << IW[i]) - 64'd1);
              e_ovf[i]   = (d >> IW[i]) != 0;
              e_valid[i] = 1'b1;
            end
          end
          e_ref[i]    = {32'h0, sum[i]} & om;
          e_primed[i] = 1'b1;
        end else if (rs[i]) begin
          e_primed[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("i%0d_s_ready", i), srdy[i],
            !e_primed[i] || rs[i] || !e_valid[i] || mr[i]);
        chk($sformatf("i%0d_m_valid", i), mval[i], e_valid[i]);
        if (e_valid[i]) begin
          chk($sformatf("i%0d_m_delta", i), get_delta(i), e_delta[i]);
          chk($sformatf("i%0d_m_ovf", i), movf[i], e_ovf[i]);
        end
        chk($sformatf("i%0d_ovf_cnt", i), ocnt[i], e_cnt[i]);
      end
    end
  end

  // Captured output beats {ovf, delta}, for the literal sequence checks
  logic [16:0] cap0[$], cap1[$], cap2[$], exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (mval[0] && mr[0]) cap0.push_back({movf[0], d0});
      if (mval[1] && mr[1]) cap1.push_back({movf[1], d1});
      if (mval[2] && mr[2]) cap2.push_back({movf[2], 12'h000, d2});
    end
  end

  task automatic clear_caps;
    cap0.delete(); cap1.delete(); cap2.delete(); exp_q.delete();
  endtask

  task automatic chk_caps(input int i, input string nm);
    logic [16:0] q[$];
    case (i)
      0:       q = cap0;
      1:       q = cap1;
      default: q = cap2;
    endcase
    chk({nm, "_beats"}, q.size(), exp_q.size());
    for (int k = 0; k < q.size() && k < exp_q.size(); k++)
      chk($sformatf("%s_beat%0d", nm, k), q[k], exp_q[k]);
    clear_caps();
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int i, input logic [31:0] v);
    logic ok;
    ok = 1'b0;
    sv[i]  = 1'b1;
    sum[i] = v;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = srdy[i];
      tick();
    end
    sv[i] = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL i%0d_send_timeout: sample 0x%0h not accepted within 20 cycles", i, v);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    clear_caps();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) sum[i] = '0;
    idle(2);
    rst    = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    chk("rst_m_valid", mval[0], 0);
    chk("rst_m_delta", d0, 0);
    chk("rst_m_ovf", movf[0], 0);
    chk("rst_ovf_cnt", ocnt[0], 0);
    chk("rst_s_ready", srdy[0], 1);
    tick();

    // Basic stream, one-cycle latency, overflow flag
    mr = 3'b111;
    clear_caps();
    send(0, 32'd5);
    @(negedge clk);
    chk("lat_m_valid", mval[0], 1);
    chk("lat_m_delta", d0, 16'd5);
    tick();
    send(0, 32'd12);
    send(0, 32'd12);
    send(0, 32'h0001_000C);
    idle(3);
    exp_q = '{17'h0_0005, 17'h0_0007, 17'h0_0000, 17'h1_0000};
    chk_caps(0, "basic");
    @(negedge clk);
    chk("basic_ovf_cnt", ocnt[0], 1);
    tick();

    // Accumulator wrap
    send(0, 32'hFFFF_FFF0);
    send(0, 32'h0000_0010);
    idle(3);
    exp_q = '{17'h1_FFE4, 17'h0_0020};
    chk_caps(0, "wrap");

    // First sample only primes when not differencing from zero
    send(1, 32'd100);
    send(1, 32'd150);
    idle(3);
    exp_q = '{17'h0_0032};
    chk_caps(1, "prime");

    // Zero differences dropped (4-bit delta / 8-bit sum instance)
    send(2, 32'd10);
    send(2, 32'd10);
    send(2, 32'd15);
    idle(3);
    exp_q = '{17'h0_000A, 17'h0_0005};
    chk_caps(2, "dropzero");

    // Backpressure: first beat held three cycles, nothing lost or duplicated
    do_reset();
    mr[0] = 1'b1; sv[0] = 1'b1; sum[0] = 32'd1;
    tick();
    mr[0] = 1'b0; sum[0] = 32'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_s_ready_%0d", k), srdy[0], 0);
      chk($sformatf("bp_m_delta_%0d", k), d0, 16'd1);
      tick();
    end
    mr[0] = 1'b1;
    tick();
    sum[0] = 32'd3;
    tick();
    sum[0] = 32'd4;
    tick();
    sv[0] = 1'b0;
    idle(3);
    exp_q = '{17'h0_0001, 17'h0_0001, 17'h0_0001, 17'h0_0001};
    chk_caps(0, "bp");

    // Restart with and without an accompanying sample
    rs[0] = 1'b1;
    send(0, 32'd1000);
    rs[0] = 1'b0;
    send(0, 32'd1003);
    rs[0] = 1'b1;
    tick();
    rs[0] = 1'b0;
    send(0, 32'd50);
    send(0, 32'd60);
    idle(3);
    exp_q = '{17'h0_0003, 17'h0_000A};
    chk_caps(0, "restart");

    // Reset with a beat pending
    mr[0] = 1'b0;
    send(0, 32'd99);
    @(negedge clk);
    chk("mid_pending", mval[0], 1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_m_valid", mval[0], 0);
    chk("mid_ovf_cnt", ocnt[0], 0);
    tick();
    rst = 1'b0;
    mr[0] = 1'b1;
    clear_caps();
    send(0, 32'd7);
    idle(3);
    exp_q = '{17'h0_0007};
    chk_caps(0, "midrst");

    // Random traffic on all instances; later portion has no resets
    for (int c = 0; c < 4000; c++) begin
      rst = (c < 1000) && ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 3; i++) begin
        sv[i] = ($urandom_range(0, 9) < 7);
        rs[i] = ($urandom_range(0, 49) == 0);
        mr[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) sum[i] = $urandom;
        else sum[i] = sum[i] + $urandom_range(0, 40);
      end
      tick();
    end
    rst = 1'b0; sv = '0; rs = '0; mr = '1;
    idle(3);
    @(negedge clk);
    chk("sat_ovf_cnt", ocnt[2], 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accum_delta.md
# accum_delta

Inverse of the running-sum accumulator. Takes a stream of accumulated sums and recovers the per-step increments as first differences modulo 2^OUT_WIDTH. Flags any difference that does not fit in IN_WIDTH bits. Sits downstream of an accumulator, or a sampled accumulator register, on a valid/ready stream, with one output register.

## Interface
- IN_WIDTH, 16: width of the recovered increment (m_delta)
- OUT_WIDTH, 32: width of the incoming running sum (s_sum); must be ≥ IN_WIDTH
- FIRST_FROM_ZERO, 1: 1 = the first sample after reset is differenced against 0 (matches an accumulator reset to 0); 0 = the first sample only primes the reference
- DROP_ZERO, 0: 1 = zero differences update the reference but produce no output beat
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- restart  input  1  force re-prime; the next accepted sample becomes the reference
- s_valid  input  1  sum sample valid
- s_ready  output  1  block accepts sample this cycle
- s_sum  input  OUT_WIDTH  running-sum sample, unsigned
- m_valid  output  1  delta beat valid
- m_ready  input  1  downstream accepts beat
- m_delta  output  IN_WIDTH  recovered increment, low IN_WIDTH bits of the difference
- m_ovf  output  1  difference ≥ 2^IN_WIDTH (upper bits nonzero)
- ovf_cnt  output  8  saturating count of emitted beats with m_ovf=1

## Operation
- State machine, two states:
  - PRIME: no valid reference.
  - RUN: prev holds the last accepted sum.
- Reset:
  - state = RUN with prev = 0 if FIRST_FROM_ZERO=1, else PRIME.
  - m_valid=0, m_delta=0, m_ovf=0, ovf_cnt=0, prev=0.
- Handshakes:
  - Accept: s_valid && s_ready.
  - Emit: m_valid && m_ready.
- s_ready:
  - 1 in PRIME or while restart=1.
  - In RUN: !m_valid || m_ready.
  - This is a combinational path from m_ready.
- PRIME, sample accepted: prev <= s_sum; state -> RUN; no output beat.
- RUN, sample accepted:
  - diff = (s_sum - prev) mod 2^OUT_WIDTH, so accumulator wrap is transparent.
  - prev <= s_sum.
  - Output register loads m_delta = diff[IN_WIDTH-1:0], m_ovf = |diff[OUT_WIDTH-1:IN_WIDTH]; m_valid <= 1.
  - m_ovf is 0 when IN_WIDTH = OUT_WIDTH.
  - DROP_ZERO=1 and diff=0: prev is updated (unchanged value); output register is not loaded.
- Emit without a new load: m_valid <= 0.
- Emit and load in the same cycle: the new beat replaces the old one; no bubble.
- ovf_cnt increments by 1 on each emitted beat with m_ovf=1 and saturates at 255. Only rst clears it.
- restart=1:
  - Sample accepted: it becomes prev, no output, state -> RUN.
  - No sample: state -> PRIME.
  - A pending output beat is not affected and still drains normally.
- rst dominates restart and all handshakes.

## Timing
- Latency 1 cycle: sample accepted at edge N gives m_valid=1 with its delta after edge N.
- Throughput: 1 beat/cycle when m_ready=1.
- m_delta and m_ovf are stable while m_valid=1 && m_ready=0.
- Output is registered; no combinational path from s_* to m_*.
- rst mid-stream: pending beat is discarded; all outputs equal their reset values after the edge.
- A restart asserted for one cycle with no sample leaves the block in PRIME until the next accept.

## Test plan
- Defaults; sums 5, 12, 12, 0x1000C, m_ready=1 → deltas 5/ovf0, 7/ovf0, 0/ovf0, 0x0000/ovf1; ovf_cnt=1; each beat appears 1 cycle after its accept.
- Wrap: prev 0xFFFFFFF0, then sum 0x00000010 → m_delta=0x0020, m_ovf=0.
- FIRST_FROM_ZERO=0: sums 100, 150 → no beat for 100; single beat 50.
- Backpressure:
  - Stimulus: s_valid=1 with sums 1,2,3,4; m_ready=0 for 3 cycles after the first beat.
  - Response: s_ready=0 while held; m_delta=1 stable; then 1,1,1,1 delivered with none lost or duplicated.
- Restart and zero-drop:
  - restart=1 with sum 1000 accepted, then 1003 → single beat 3.
  - DROP_ZERO=1, sums 10, 10, 15 → beats 10, 5 only.
- Reset mid-stream: rst while m_valid=1 → next cycle m_valid=0, ovf_cnt=0; sum 7 then gives delta 7 (FIRST_FROM_ZERO=1).
